// File: rtl/aes_ctr_stream.sv
// -----------------------------------------------------------------------------
// aes_ctr_stream
//
// CTR-mode sequencer sitting directly in front of an AES core. It loads the
// key into the core, walks a counter block, asks the core for one keystream
// block per input block and XORs that keystream with the buffered input.
// Encrypt and decrypt are the same operation, so the core is always driven
// in encipher mode.
//
// Exactly one block is in flight at a time: input is accepted only in
// WAIT_IN, and the next input is not accepted until the previous output has
// been taken.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start             one-cycle pulse, latches key/keylen/iv (idle only)
//   cfg_key[255:0]        key, AES-128 uses [255:128]
//   cfg_keylen            0 = AES-128, 1 = AES-256
//   cfg_iv[127:0]         initial counter block
//   busy                  high from accepted cfg_start to the last output
//   in_valid/in_ready     input stream handshake
//   in_data[127:0]        plaintext or ciphertext block
//   in_last               final block of the message
//   out_valid/out_ready   output stream handshake
//   out_data[127:0]       in_data XOR E(K, ctr)
//   out_last              in_last of this block
//   core_encdec           constant 1 (encipher)
//   core_init, core_next  one-cycle command pulses to the core
//   core_key, core_keylen registered key and key length
//   core_block[127:0]     current counter block
//   core_ready            pulse, key expansion finished
//   core_result[127:0]    keystream, valid with core_result_valid
//   core_result_valid     pulse, keystream block available
//
// Parameters
//   CTR_W                 width of the incrementing low part of the counter
// -----------------------------------------------------------------------------
module aes_ctr_stream #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         cfg_start,
  input  logic [255:0] cfg_key,
  input  logic         cfg_keylen,
  input  logic [127:0] cfg_iv,
  output logic         busy,

  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,

  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,

  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid
);

  // Selects the bits of the counter block that increment. Built by shifting
  // so that CTR_W = 128 yields an all-ones mask instead of a zero-width slice.
  localparam logic [127:0] LOW_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KINIT,
    ST_KWAIT,
    ST_WAIT_IN,
    ST_RUN,
    ST_OUT
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [255:0] key_reg;
  logic         keylen_reg;
  logic [127:0] ctr_reg;
  logic [127:0] data_reg;
  logic         last_reg;
  logic [127:0] out_data_reg;
  logic         out_last_reg;
  logic         next_sent;

  logic         in_hs;
  logic         out_hs;
  logic [127:0] ctr_inc;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Full-width add, then keep only the low CTR_W bits of the sum: the low
  // part wraps silently and the carry never reaches the fixed upper bits.
  assign ctr_inc = (ctr_reg & ~LOW_MASK) | ((ctr_reg + 128'd1) & LOW_MASK);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/command outputs. core_next is gated by
  // next_sent so it fires only in the first RUN cycle; a result pulse is
  // only taken after the command went out, so a stray pulse in the same
  // cycle as core_next cannot be mistaken for the answer.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          state_next = ST_KINIT;
        end
      end

      ST_KINIT: begin
        core_init  = 1'b1;
        state_next = ST_KWAIT;
      end

      ST_KWAIT: begin
        if (core_ready) begin
          state_next = ST_WAIT_IN;
        end
      end

      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        core_next = ~next_sent;
        if (next_sent && core_result_valid) begin
          state_next = ST_OUT;
        end
      end

      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = out_last_reg ? ST_IDLE : ST_WAIT_IN;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Configuration and counter registers. Key and keylen only change on an
  // accepted start, so they stay stable through every core operation of
  // the message. The counter advances after a non-final output is taken,
  // which keeps core_block stable from core_next until its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      keylen_reg <= 1'b0;
      ctr_reg    <= '0;
    end else begin
      if (state == ST_IDLE && cfg_start) begin
        key_reg    <= cfg_key;
        keylen_reg <= cfg_keylen;
        ctr_reg    <= cfg_iv;
      end else if (state == ST_OUT && out_ready && !out_last_reg) begin
        ctr_reg <= ctr_inc;
      end
    end
  end

  // Block datapath: buffer the input block, remember whether core_next has
  // been issued for it, and capture the XOR result when the keystream
  // arrives. The output registers hold until the next result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg     <= '0;
      last_reg     <= 1'b0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
      next_sent    <= 1'b0;
    end else begin
      if (in_hs) begin
        data_reg <= in_data;
        last_reg <= in_last;
      end

      if (state == ST_RUN) begin
        if (!next_sent) begin
          next_sent <= 1'b1;
        end else if (core_result_valid) begin
          out_data_reg <= core_result ^ data_reg;
          out_last_reg <= last_reg;
          next_sent    <= 1'b0;
        end
      end
    end
  end

  assign out_data    = out_data_reg;
  assign out_last    = out_last_reg;
  assign core_encdec = 1'b1;
  assign core_key    = key_reg;
  assign core_keylen = keylen_reg;
  assign core_block  = ctr_reg;

  logic unused_ok;
  assign unused_ok = out_hs;

endmodule
